cnt_checker: RTL

- Consumer-side monitor for the free-running Counter block.
- Samples the counter's 8-bit output stream and checks that every sample equals the previous sample plus STEP, modulo 2^WIDTH.
- Keeps sticky error status, a saturating error count, and the first mismatch pair.
- Owns the run-cycle counter and asserts a done flag at HALT_CYCLE, so synthesizable tops and benches share one self-checking end point.

---
 rtl/cnt_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/cnt_checker.sv
// Consumer-side monitor for a free-running counter stream: checks each sample
// against previous+STEP, keeps error status, and ends the run at HALT_CYCLE.
module cnt_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HALT_CYCLE = 1000
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             I_EN,
  input  logic [WIDTH-1:0] I_CNT,
  output logic             O_SYNC,
  output logic             O_ERR,
  output logic [15:0]      O_ERR_CNT,
  output logic [WIDTH-1:0] O_FIRST_EXP,
  output logic [WIDTH-1:0] O_FIRST_GOT,
  output logic [31:0]      O_CYCLE,
  output logic             O_DONE
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    HALT
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] exp_q;
  logic             sync_q;
  logic             err_q;
  logic [15:0]      err_cnt_q;
  logic [WIDTH-1:0] first_exp_q;
  logic [WIDTH-1:0] first_got_q;
  logic [31:0]      cycle_q;
  logic             done_q;

  logic [WIDTH-1:0] exp_d;
  logic [31:0]      cycle_d;

  // Next expected value is always derived from the received sample, which
  // gives automatic resync after a mismatch.
  always_comb begin
    exp_d   = I_CNT + STEP_W;
    cycle_d = cycle_q + 32'd1;
  end

  // NOTE: every register here is assigned with <= so all updates on an edge
  // see the pre-edge values (e.g. err_q gates the first-mismatch capture).
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      sync_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
    end else if (state_q != HALT) begin
      cycle_q <= cycle_d;

      case (state_q)
        IDLE: begin
          if (I_EN) begin
            exp_q   <= exp_d;
            sync_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (I_EN) begin
            exp_q <= exp_d;
            if (I_CNT != exp_q) begin
              err_q <= 1'b1;
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
              end
              if (!err_q) begin
                first_exp_q <= exp_q;
                first_got_q <= I_CNT;
              end
            end
          end
        end
        default: state_q <= HALT;
      endcase

      // Placed after the case so the halt transition wins over IDLE->CHECK.
      if (cycle_d == HALT_CYCLE) begin
        done_q  <= 1'b1;
        state_q <= HALT;
      end
    end
  end

  assign O_SYNC      = sync_q;
  assign O_ERR       = err_q;
  assign O_ERR_CNT   = err_cnt_q;
  assign O_FIRST_EXP = first_exp_q;
  assign O_FIRST_GOT = first_got_q;
  assign O_CYCLE     = cycle_q;
  assign O_DONE      = done_q;

endmodule
